ghostbus_arbiter: RTL and testbench
===================================

# ghostbus_arbiter

Two-port arbiter sharing a single ghostbus host port between two bus masters, for example a UART bridge and a packet bridge. It serializes one transaction at a time onto the ghostbus address/data/strobe lines that feed auto-decoded host-accessible registers and RAMs. For reads it waits a fixed read latency and returns the captured data to the owning requester. Grants are round-robin between simultaneous requesters; an optional lock lets one master hold the bus for a burst.

## Interface
- AW, 24, ghostbus address width
- DW, 32, ghostbus data width
- RD_LAT, 1, cycles from read strobe to valid gb_rdata; legal range 1..15
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  (N=0,1) transaction request; held high, with fields stable, until reqN_done
- reqN_addr  in  AW  request address
- reqN_wdata  in  DW  write data
- reqN_we  in  1  1=write, 0=read
- reqN_done  out  1  one-cycle completion pulse
- reqN_rdata  out  DW  read data; valid while reqN_done is high
- gb_addr  out  AW  ghostbus address
- gb_wdata  out  DW  ghostbus write data
- gb_we  out  1  one-cycle write strobe
- gb_re  out  1  one-cycle read strobe
- gb_rdata  in  DW  ghostbus read data, valid RD_LAT cycles after gb_re

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset enters IDLE.
- IDLE: if any reqN_valid is high, latch the grant, addr, wdata and we, then go to ISSUE.
  - Both valid: grant the requester that was not granted last.
  - `last` resets to 1, so req0 wins the first contention.
- ISSUE (1 cycle):
  - Drive gb_addr and gb_wdata from the latched copies.
  - Assert gb_we for a write or gb_re for a read.
  - Write: go to DONE. Read: load the latency counter with RD_LAT−1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture gb_rdata into the rdata register, go to DONE, and set `last` to the current grant.
- DONE (1 cycle):
  - Pulse done for the granted requester. reqN_rdata shows the captured data; it holds the last captured value otherwise.
  - Go to IDLE. A write also updates `last` here.
- The non-granted requester's valid is ignored until the arbiter is back in IDLE; its request stays pending.
- Dropping reqN_valid mid-transaction does not abort it; the transaction completes and done still pulses.
- gb_addr and gb_wdata hold their last values outside ISSUE. Strobes are exactly one cycle wide.

## Timing
- Reset values: gb_we=0, gb_re=0, gb_addr=0, gb_wdata=0, reqN_done=0, reqN_rdata=0, state=IDLE, counter=0.
- rst high mid-transaction: return to IDLE next edge with all outputs at reset values. A pending strobe is suppressed; no done is issued.
- Write accepted in IDLE at cycle t: gb_we at t+1, done at t+2.
- Read accepted in IDLE at cycle t: gb_re at t+1, gb_rdata sampled at t+1+RD_LAT, done at t+2+RD_LAT.
- Minimum spacing between grants is 3 cycles for writes and 3+RD_LAT cycles for reads.
- With both requesters streaming writes, grants alternate 0,1,0,1 with a done every 3 cycles.

## Configuration
- GHOSTBUS_ARB_LOCK_EN defined:
  - Adds inputs reqN_lock (1 bit each).
  - If the last-granted requester has lock high in IDLE, it wins over a valid from the other requester.
  - Lock is evaluated only in IDLE.
  - Deasserting lock restores round-robin from the next IDLE.
- Undefined: the lock ports do not exist and arbitration is pure round-robin.

## Structure
- Package ghostbus_arb_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, DONE);
  - the counter width constant (4 bits);
  - the reset value of `last`.
- Sub-module ghostbus_arb_rr: combinational 2-way round-robin picker, plus lock override when enabled. Inputs are valid[1:0], last and lock[1:0]; outputs are grant and any. The rest stays in ghostbus_arbiter.

## Test plan
- Single write, req0 addr 0x000010, data 0xDEADBEEF, we=1: gb_we pulses 1 cycle with that addr/data; req0_done 2 cycles after acceptance; req1_done stays 0.
- Single read, RD_LAT=3, req1 addr 0x000100, bench returns 0x42 three cycles after gb_re: req1_rdata=0x42 with req1_done 5 cycles after acceptance.
- Both requesters assert writes in the same cycle after reset: req0 served first, then req1. Continuous requests alternate 0,1,0,1 over 8 transactions.
- rst asserted during WAIT of a read: no done pulse, all outputs zero next cycle; the retried request completes normally.
- GHOSTBUS_ARB_LOCK_EN defined, req0 locked with 4 back-to-back writes while req1 is valid: all 4 go to req0 before req1 is granted.
- req0 drops valid in the cycle after ISSUE: the transaction still completes and req0_done pulses once.

Source files
------------

// File: rtl/ghostbus_arb_pkg.sv
// Shared types and constants for the ghostbus arbiter.
// The optional lock feature is enabled with `define GHOSTBUS_ARB_LOCK_EN.
package ghostbus_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int   CNT_W    = 4;
  localparam logic LAST_RST = 1'b1;
endpackage

// File: rtl/ghostbus_arb_rr.sv
// Combinational 2-way round-robin picker with lock override.
// Callers tie lock to 0 when GHOSTBUS_ARB_LOCK_EN is not defined.
module ghostbus_arb_rr
  import ghostbus_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  input  logic [1:0] lock,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = valid[0] | valid[1];
    grant = valid[1];
    // On contention a locked previous owner keeps the bus, otherwise alternate.
    if (&valid) begin
      grant = lock[last] ? last : ~last;
    end
  end

endmodule

// File: rtl/ghostbus_arbiter.sv
// Two-master arbiter serializing transactions onto one ghostbus host port.
// Define GHOSTBUS_ARB_LOCK_EN to add reqN_lock inputs for burst ownership.
module ghostbus_arbiter
  import ghostbus_arb_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_we,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_we,
`ifdef GHOSTBUS_ARB_LOCK_EN
  input  logic          req0_lock,
  input  logic          req1_lock,
`endif
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  state_t           state;
  logic             grant_reg;
  logic             last_reg;
  logic             we_reg;
  logic [AW-1:0]    addr_reg;
  logic [DW-1:0]    wdata_reg;
  logic [DW-1:0]    rdata_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [1:0] lock;
  logic       pick;
  logic       any;

`ifdef GHOSTBUS_ARB_LOCK_EN
  assign lock = {req1_lock, req0_lock};
`else
  assign lock = 2'b00;
`endif

  ghostbus_arb_rr u_rr (
    .valid ({req1_valid, req0_valid}),
    .last  (last_reg),
    .lock  (lock),
    .grant (pick),
    .any   (any)
  );

  // Both requesters see the one capture register; it is only meaningful during done.
  assign req0_rdata = rdata_reg;
  assign req1_rdata = rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_reg <= 1'b0;
      last_reg  <= LAST_RST;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
      gb_addr   <= '0;
      gb_wdata  <= '0;
      gb_we     <= 1'b0;
      gb_re     <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
    end else begin
      gb_we     <= 1'b0;
      gb_re     <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant_reg <= pick;
            addr_reg  <= pick ? req1_addr  : req0_addr;
            wdata_reg <= pick ? req1_wdata : req0_wdata;
            we_reg    <= pick ? req1_we    : req0_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          gb_addr  <= addr_reg;
          gb_wdata <= wdata_reg;
          if (we_reg) begin
            gb_we <= 1'b1;
            state <= DONE;
          end else begin
            gb_re   <= 1'b1;
            cnt_reg <= CNT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            rdata_reg <= gb_rdata;
            last_reg  <= grant_reg;
            state     <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          req0_done <= ~grant_reg;
          req1_done <= grant_reg;
          if (we_reg) last_reg <= grant_reg;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghostbus_arbiter.sv
// Directed bench for ghostbus_arbiter with a 3-cycle read-latency bus model.
// Build with +define+GHOSTBUS_ARB_LOCK_EN to include the lock scenario.
module tb_ghostbus_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic req0_we = 1'b0, req1_we = 1'b0;
`ifdef GHOSTBUS_ARB_LOCK_EN
  logic req0_lock = 1'b0, req1_lock = 1'b0;
`endif
  logic req0_done, req1_done;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic gb_we, gb_re;
  logic [DW-1:0] gb_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ghostbus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_we(req0_we),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_we(req1_we),
`ifdef GHOSTBUS_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
    .gb_rdata(gb_rdata)
  );

  // Bus model: read data is valid only in the single cycle RD_LAT after gb_re.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 24'h000100) return 32'h0000_0042;
    return {8'h00, a} ^ 32'h1357_0000;
  endfunction

  logic [1:0] pv = 2'b00;
  logic [DW-1:0] pd0 = '0, pd1 = '0;
  always @(posedge clk) begin
    pv[0] <= gb_re;
    pd0   <= rd_model(gb_addr);
    pv[1] <= pv[0];
    pd1   <= pd0;
  end
  assign gb_rdata = pv[1] ? pd1 : 32'hBAAD_F00D;

  task automatic do_reset;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (gb_we !== 1'b0) begin fails++; $display("FAIL reset gb_we got %b exp 0", gb_we); end
    tests++; if (gb_re !== 1'b0) begin fails++; $display("FAIL reset gb_re got %b exp 0", gb_re); end
    tests++; if (gb_addr !== '0) begin fails++; $display("FAIL reset gb_addr got %h exp 0", gb_addr); end
    tests++; if (gb_wdata !== '0) begin fails++; $display("FAIL reset gb_wdata got %h exp 0", gb_wdata); end
    tests++; if ({req0_done, req1_done} !== 2'b00) begin fails++; $display("FAIL reset done got %b exp 00", {req0_done, req1_done}); end
    tests++; if (req0_rdata !== '0 || req1_rdata !== '0) begin fails++; $display("FAIL reset rdata got %h/%h exp 0", req0_rdata, req1_rdata); end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_single_write;
    req0_addr = 24'h000010; req0_wdata = 32'hDEADBEEF; req0_we = 1'b1; req0_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (gb_we !== (k == 2)) begin fails++; $display("FAIL wr gb_we k=%0d got %b exp %b", k, gb_we, k == 2); end
      tests++; if (req0_done !== (k == 3)) begin fails++; $display("FAIL wr req0_done k=%0d got %b exp %b", k, req0_done, k == 3); end
      tests++; if (req1_done !== 1'b0 || gb_re !== 1'b0) begin fails++; $display("FAIL wr req1_done/gb_re k=%0d got %b%b exp 00", k, req1_done, gb_re); end
      if (k == 2 || k == 5) begin
        tests++; if (gb_addr !== 24'h000010 || gb_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr bus k=%0d got %h/%h exp 000010/deadbeef", k, gb_addr, gb_wdata); end
      end
      if (k == 3) req0_valid = 1'b0;
    end
    $display("[TB] single write req0 addr 000010 data deadbeef");
  endtask

  task automatic test_single_read;
    req1_addr = 24'h000100; req1_we = 1'b0; req1_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (gb_re !== (k == 2)) begin fails++; $display("FAIL rd gb_re k=%0d got %b exp %b", k, gb_re, k == 2); end
      tests++; if (req1_done !== (k == 6)) begin fails++; $display("FAIL rd req1_done k=%0d got %b exp %b", k, req1_done, k == 6); end
      tests++; if (req0_done !== 1'b0 || gb_we !== 1'b0) begin fails++; $display("FAIL rd req0_done/gb_we k=%0d got %b%b exp 00", k, req0_done, gb_we); end
      if (k == 6) begin
        tests++; if (req1_rdata !== 32'h42) begin fails++; $display("FAIL rd req1_rdata got %h exp 00000042", req1_rdata); end
        req1_valid = 1'b0;
      end
    end
    $display("[TB] single read req1 addr 000100 rdata %h", req1_rdata);
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] ea;
    do_reset();
    req0_addr = 24'h0000A0; req0_wdata = 32'h1111_0000; req0_we = 1'b1;
    req1_addr = 24'h0000B0; req1_wdata = 32'h2222_0000; req1_we = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (req0_done !== (k % 3 == 0 && (k / 3 - 1) % 2 == 0)) begin fails++; $display("FAIL rr req0_done k=%0d got %b", k, req0_done); end
      tests++; if (req1_done !== (k % 3 == 0 && (k / 3 - 1) % 2 == 1)) begin fails++; $display("FAIL rr req1_done k=%0d got %b", k, req1_done); end
      tests++; if (gb_we !== (k % 3 == 2)) begin fails++; $display("FAIL rr gb_we k=%0d got %b exp %b", k, gb_we, k % 3 == 2); end
      if (k % 3 == 2) begin
        ea = (((k - 2) / 3) % 2 == 0) ? 24'h0000A0 : 24'h0000B0;
        tests++; if (gb_addr !== ea) begin fails++; $display("FAIL rr gb_addr k=%0d got %h exp %h", k, gb_addr, ea); end
      end
      if (k == 24) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    $display("[TB] back-to-back alternating writes x8");
  endtask

  task automatic test_reset_mid;
    req0_addr = 24'h000200; req0_we = 1'b0; req0_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    tests++; if ({gb_we, gb_re, req0_done, req1_done} !== 4'b0000) begin fails++; $display("FAIL rstmid strobes got %b exp 0000", {gb_we, gb_re, req0_done, req1_done}); end
    tests++; if (gb_addr !== '0 || gb_wdata !== '0) begin fails++; $display("FAIL rstmid bus got %h/%h exp 0/0", gb_addr, gb_wdata); end
    tests++; if (req0_rdata !== '0 || req1_rdata !== '0) begin fails++; $display("FAIL rstmid rdata got %h/%h exp 0", req0_rdata, req1_rdata); end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (req0_done !== (k == 6)) begin fails++; $display("FAIL rstmid retry done k=%0d got %b exp %b", k, req0_done, k == 6); end
      if (k == 6) begin
        tests++; if (req0_rdata !== 32'h1357_0200) begin fails++; $display("FAIL rstmid retry rdata got %h exp 13570200", req0_rdata); end
        req0_valid = 1'b0;
      end
    end
    $display("[TB] reset during read wait, retry rdata %h", req0_rdata);
  endtask

  task automatic test_drop_valid;
    int ndone = 0;
    req0_addr = 24'h000300; req0_we = 1'b0; req0_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 2) req0_valid = 1'b0;
      if (req0_done) ndone++;
      if (k == 6) begin
        tests++; if (req0_done !== 1'b1) begin fails++; $display("FAIL drop done k=6 got %b exp 1", req0_done); end
        tests++; if (req0_rdata !== 32'h1357_0300) begin fails++; $display("FAIL drop rdata got %h exp 13570300", req0_rdata); end
      end
    end
    tests++; if (ndone != 1) begin fails++; $display("FAIL drop done count got %0d exp 1", ndone); end
    $display("[TB] dropped valid, done pulses %0d", ndone);
  endtask

`ifdef GHOSTBUS_ARB_LOCK_EN
  task automatic test_lock;
    do_reset();
    req0_addr = 24'h0000C0; req0_wdata = 32'h3333_0000; req0_we = 1'b1; req0_lock = 1'b1;
    req1_addr = 24'h0000D0; req1_wdata = 32'h4444_0000; req1_we = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (req0_done !== (k % 3 == 0 && k <= 12)) begin fails++; $display("FAIL lock req0_done k=%0d got %b", k, req0_done); end
      tests++; if (req1_done !== (k == 15)) begin fails++; $display("FAIL lock req1_done k=%0d got %b", k, req1_done); end
      if (k == 12) begin req0_valid = 1'b0; req0_lock = 1'b0; end
      if (k == 15) req1_valid = 1'b0;
    end
    $display("[TB] lock burst req0 x4 then req1");
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_reset_mid();
    test_drop_valid();
`ifdef GHOSTBUS_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
